// File: rtl/queue_dispatcher_pkg.sv
// rtl/queue_dispatcher_pkg.sv - shared constants, state encoding and decoder for the queue bank
// Purpose: class-field geometry, PASS/HOLD encoding (shared with the
// round-robin reader) and the one-hot queue-select decoder.
package queue_dispatcher_pkg;

  localparam int QUEUE_QUANTITY = 4;
  localparam int SEL_BITS       = 2;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } disp_state_t;

  // Class field occupies the top SEL_BITS bits of a word.
  function automatic int class_msb(input int data_bits);
    return data_bits - 1;
  endfunction

  function automatic int class_lsb(input int data_bits);
    return data_bits - SEL_BITS;
  endfunction

  function automatic logic [QUEUE_QUANTITY-1:0] onehot(input logic [SEL_BITS-1:0] sel);
    logic [QUEUE_QUANTITY-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/queue_dispatcher.sv
// rtl/queue_dispatcher.sv - steers an ingress word stream into one of four FIFOs by class
// Purpose: writes each accepted word to the FIFO named by its class bits,
// stalling upstream (HOLD) while the target FIFO reports almost-full.
// Optional build macro QUEUE_DISPATCHER_DROP_EN: words aimed at a full FIFO
// are discarded and counted instead of stalling.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   enb              block enable; 0 freezes state and suppresses push
//   data_in/valid_in incoming word and its valid
//   ready_out        word can be accepted this cycle (combinational)
//   buf_full         per-FIFO almost-full flags
//   data_out/push    registered word and one-hot write strobe to the FIFOs
//   drop_count       saturating dropped-word count (0 unless drop build)
module queue_dispatcher
  import queue_dispatcher_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [DATA_BITS-1:0]      data_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [QUEUE_QUANTITY-1:0] buf_full,
  output logic [DATA_BITS-1:0]      data_out,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [7:0]                drop_count
);

  localparam int CLS_MSB = class_msb(DATA_BITS);
  localparam int CLS_LSB = class_lsb(DATA_BITS);

  logic [DATA_BITS-1:0]      data_q;
  logic [QUEUE_QUANTITY-1:0] push_q;
  logic [SEL_BITS-1:0]       dest;

  assign dest     = data_in[CLS_MSB:CLS_LSB];
  assign data_out = data_q;
  assign push     = push_q;

`ifdef QUEUE_DISPATCHER_DROP_EN
  logic [7:0] drop_q;
  logic [7:0] drop_d;

  assign drop_d     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
  assign drop_count = drop_q;
  // Never stalls: a word for a full queue is simply discarded.
  assign ready_out  = enb && !rst;
`else
  disp_state_t          state_q;
  logic [DATA_BITS-1:0] held_q;
  logic [SEL_BITS-1:0]  held_dest;

  assign held_dest  = held_q[CLS_MSB:CLS_LSB];
  assign drop_count = 8'd0;
  assign ready_out  = (state_q == ST_PASS) && enb && !rst;
`endif

  // In PASS with enb=1 and rst=0 ready_out is high, so valid_in alone means accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      push_q  <= '0;
`ifdef QUEUE_DISPATCHER_DROP_EN
      drop_q  <= '0;
`else
      state_q <= ST_PASS;
      held_q  <= '0;
`endif
    end else if (!enb) begin
      push_q <= '0;
`ifndef QUEUE_DISPATCHER_DROP_EN
    end else if (state_q == ST_HOLD) begin
      // Only the held word's own queue is consulted; ingress stays blocked
      // on the release edge because ready_out was low during it.
      if (!buf_full[held_dest]) begin
        data_q  <= held_q;
        push_q  <= onehot(held_dest);
        state_q <= ST_PASS;
      end else begin
        push_q <= '0;
      end
`endif
    end else if (valid_in && !buf_full[dest]) begin
      data_q <= data_in;
      push_q <= onehot(dest);
    end else if (valid_in) begin
      push_q <= '0;
`ifdef QUEUE_DISPATCHER_DROP_EN
      drop_q <= drop_d;
`else
      held_q  <= data_in;
      state_q <= ST_HOLD;
`endif
    end else begin
      push_q <= '0;
    end
  end

endmodule

// File: tb/tb_queue_dispatcher.sv
// tb/tb_queue_dispatcher.sv - scoreboard bench for queue_dispatcher with a word-level reference model
module tb_queue_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic [3:0] buf_full = 4'h0;
  logic [7:0] data_out;
  logic [3:0] push;
  logic [7:0] drop_count;

  queue_dispatcher #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .buf_full  (buf_full),
    .data_out  (data_out),
    .push      (push),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         cyc;
    logic [3:0] push;
    logic [7:0] data;
    bit         is_rst;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: is a word parked waiting for its queue, and which one.
  bit         m_holding = 0;
  logic [7:0] m_word    = 8'h00;
  int         m_drop    = 0;
  bit         m_init    = 0;

  // Monitor: every cycle after the first reset, push and data_out must equal
  // what the scoreboard says for that cycle (push 0 and last data otherwise).
  bit         armed    = 0;
  logic [7:0] mon_data = 8'h00;

  always @(negedge clk) begin
    logic [3:0] exp_push;
    exp_t       e;
    exp_push = 4'h0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e        = sb.pop_front();
      exp_push = e.push;
      mon_data = e.data;
      if (e.is_rst) armed = 1;
    end
    if (armed) begin
      chk("push", {28'd0, push}, {28'd0, exp_push});
      chk("data_out", {24'd0, data_out}, {24'd0, mon_data});
    end
  end

  task automatic expect_push(input logic [7:0] w);
    exp_t e;
    e.cyc    = cyc + 1;
    e.push   = 4'b0001 << w[7:6];
    e.data   = w;
    e.is_rst = 0;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, check ready_out/drop_count, then advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] f,
                      input logic e, input logic r);
    bit   exp_ready;
    exp_t er;
    valid_in = v;
    data_in  = d;
    buf_full = f;
    enb      = e;
    rst      = r;
    #1;
    exp_ready = e && !r && !m_holding;
    chk("ready_out", {31'd0, ready_out}, {31'd0, exp_ready});
    if (m_init) chk("drop_count", {24'd0, drop_count}, m_drop);
    if (r) begin
      m_holding = 0;
      m_drop    = 0;
      m_init    = 1;
      er.cyc = cyc + 1; er.push = 4'h0; er.data = 8'h00; er.is_rst = 1;
      sb.push_back(er);
    end else if (e) begin
      if (m_holding) begin
        if (!f[m_word[7:6]]) begin
          expect_push(m_word);
          m_holding = 0;
        end
      end else if (v && exp_ready) begin
        if (!f[d[7:6]]) begin
          expect_push(d);
        end else begin
`ifdef QUEUE_DISPATCHER_DROP_EN
          if (m_drop < 255) m_drop++;
`else
          m_holding = 1;
          m_word    = d;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] f;
    @(posedge clk);
    #1;
    // reset for two cycles
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
    // streaming, one per queue, no bubbles
    step(1'b1, 8'h05, 4'h0, 1'b1, 1'b0);
    step(1'b1, 8'h47, 4'h0, 1'b1, 1'b0);
    step(1'b1, 8'h8A, 4'h0, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 4'h0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    // stall on queue 2, release after 3 cycles
    step(1'b1, 8'h9E, 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h33, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 8'h33, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
    // only the target queue's flag matters
    step(1'b1, 8'h11, 4'b1110, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b1110, 1'b1, 1'b0);
    // enable low while the held word's queue frees up
    step(1'b1, 8'h9E, 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h22, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
    // reset while holding discards the word
    step(1'b1, 8'hB7, 4'b0100, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0100, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
`ifdef QUEUE_DISPATCHER_DROP_EN
    for (int i = 0; i < 300; i++) step(1'b1, 8'hF0, 4'b1000, 1'b1, 1'b0);
    chk("drop_saturated", {24'd0, drop_count}, 32'd255);
`endif
    // randomized traffic with sticky full flags, occasional enable/reset
    f = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) f = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 9) < 7), 8'($urandom),
           f, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
